// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types.
//   word_t          32-bit datapath word
//   regbits_t       register-file select
//   memstate_t      MEM-stage access FSM states
//   WORD_ALIGN_MASK low address bits that must be zero for a word access
//   lui_word()      builds the LUI writeback word from an instruction
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } memstate_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic word_t lui_word(input word_t instr);
    return {instr[15:0], 16'h0000};
  endfunction

endpackage

// File: rtl/mem_wb_latch.sv
// mem_wb_latch: MEM/WB pipeline register.
//   CLK, nRST        clock, async active-low reset
//   en_i             load new writeback values
//   bubble_i         load a bubble (all fields cleared); wins over en_i
//   wen_i/wsel_i/wdat_i  writeback enable, select, data in
//   wen_o/wsel_o/wdat_o  registered writeback to the register file
module mem_wb_latch
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     en_i,
  input  logic     bubble_i,
  input  logic     wen_i,
  input  regbits_t wsel_i,
  input  word_t    wdat_i,
  output logic     wen_o,
  output regbits_t wsel_o,
  output word_t    wdat_o
);

  logic     wen_q;
  regbits_t wsel_q;
  word_t    wdat_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
    end else if (bubble_i) begin
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
    end else if (en_i) begin
      wen_q  <= wen_i;
      wsel_q <= wsel_i;
      wdat_q <= wdat_i;
    end
  end

  assign wen_o  = wen_q;
  assign wsel_o = wsel_q;
  assign wdat_o = wdat_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline.
//   Inputs : CLK, nRST (async active-low), memEN (hazard advance enable),
//            EX/MEM control (memcuDRE/DWE/HALT, memMemToReg, memWEN,
//            memLUIflag), memwsel, memOutput_Port (ALU result / address),
//            memrdat2 (store data), meminstr, dhit, dmemload.
//   Outputs: dmemREN/dmemWEN/dmemaddr/dmemstore (data-memory request),
//            memStall, memErr (sticky misalign/timeout), wbWEN/wbwsel/wbwdat
//            (MEM/WB latch), wbHALT (sticky).
//   Parameter TIMEOUT: dhit wait cycles before memErr asserts.
//   Optional build macro MEM_STAGE_PERF_EN adds perfAccesses and
//   perfStallCycles counters.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        memEN,
  input  logic        memcuDRE,
  input  logic        memcuDWE,
  input  logic        memcuHALT,
  input  logic        memMemToReg,
  input  logic        memWEN,
  input  logic        memLUIflag,
  input  logic [4:0]  memwsel,
  input  logic [31:0] memOutput_Port,
  input  logic [31:0] memrdat2,
  input  logic [31:0] meminstr,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        memStall,
  output logic        memErr,
  output logic        wbWEN,
  output logic [4:0]  wbwsel,
  output logic [31:0] wbwdat,
  output logic        wbHALT
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0] perfAccesses,
  output logic [31:0] perfStallCycles
`endif
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

  memstate_t     state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  word_t         load_q, load_d;
  logic          err_q, err_d;
  logic          halt_q, halt_d;

  logic  req_en, access, retire, misaligned, bubble;
  word_t load_word, wdat;

  // Requests are gated by nRST so they drop the instant reset asserts,
  // even though the EX/MEM inputs may still be presenting an access.
  always_comb begin
    req_en     = nRST && (state_q == IDLE || state_q == BUSY);
    access     = req_en && (memcuDRE || memcuDWE);
    dmemWEN    = req_en && memcuDWE;
    dmemREN    = req_en && memcuDRE && !memcuDWE;  // write wins
    dmemaddr   = req_en ? memOutput_Port : '0;
    dmemstore  = req_en ? memrdat2 : '0;
    memStall   = access && !dhit;
    retire     = nRST && memEN && !memStall && (state_q != HALTED);
    misaligned = access && (|(memOutput_Port[1:0] & WORD_ALIGN_MASK));
    bubble     = memStall || (state_q == HALTED);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, BUSY: begin
        if (access) begin
          if (dhit) begin
            if (memEN) state_d = memcuHALT ? HALTED : IDLE;
            else       state_d = DONE;  // park so the access is not re-issued
          end else begin
            state_d = BUSY;
          end
        end else if (retire) begin
          state_d = memcuHALT ? HALTED : IDLE;
        end
      end
      DONE: begin
        if (retire) state_d = memcuHALT ? HALTED : IDLE;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Timeout counter saturates; error latches on the cycle it reaches TIMEOUT.
  always_comb begin
    tmo_d = '0;
    if (memStall) tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    err_d  = err_q || misaligned || (memStall && (tmo_d == TMO_MAX));
    load_d = (access && dhit) ? dmemload : load_q;
    halt_d = halt_q || (retire && memcuHALT);
  end

  // Load data is live from memory on the dhit cycle, captured once parked.
  always_comb begin
    load_word = (state_q == DONE) ? load_q : dmemload;
    if (memLUIflag)       wdat = lui_word(meminstr);
    else if (memMemToReg) wdat = load_word;
    else                  wdat = memOutput_Port;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      load_q  <= load_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  mem_wb_latch u_mem_wb_latch (
    .CLK      (CLK),
    .nRST     (nRST),
    .en_i     (retire),
    .bubble_i (bubble),
    .wen_i    (memWEN),
    .wsel_i   (memwsel),
    .wdat_i   (wdat),
    .wen_o    (wbWEN),
    .wsel_o   (wbwsel),
    .wdat_o   (wbwdat)
  );

  assign memErr = err_q;
  assign wbHALT = halt_q;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] acc_cnt_q, stall_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire && (access || state_q == DONE)) acc_cnt_q <= acc_cnt_q + 32'd1;
      if (memStall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perfAccesses    = acc_cnt_q;
  assign perfStallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        memEN, memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN, memLUIflag;
  logic [4:0]  memwsel;
  logic [31:0] memOutput_Port, memrdat2, meminstr;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, memStall, memErr, wbWEN, wbHALT;
  logic [31:0] dmemaddr, dmemstore, wbwdat;
  logic [4:0]  wbwsel;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0] perfAccesses, perfStallCycles;
`endif

  mem_stage dut (
    .CLK(CLK), .nRST(nRST), .memEN(memEN),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
    .memMemToReg(memMemToReg), .memWEN(memWEN), .memLUIflag(memLUIflag),
    .memwsel(memwsel), .memOutput_Port(memOutput_Port), .memrdat2(memrdat2),
    .meminstr(meminstr), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .memStall(memStall), .memErr(memErr), .wbWEN(wbWEN), .wbwsel(wbwsel),
    .wbwdat(wbwdat), .wbHALT(wbHALT)
`ifdef MEM_STAGE_PERF_EN
    , .perfAccesses(perfAccesses), .perfStallCycles(perfStallCycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  wsel;
    logic [31:0] wdat;
  } wb_t;

  wb_t sb[$];
  int  n_chk = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] ws, input logic [31:0] wd);
    wb_t e;
    e.wsel = ws;
    e.wdat = wd;
    sb.push_back(e);
  endtask

  // Monitor: every register-file write the DUT presents is matched in order.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && wbWEN === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL wb_unexpected: got wsel=%0d wdat=%h want no write", wbwsel, wbwdat);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_wsel", {27'd0, wbwsel}, {27'd0, e.wsel});
        chk("wb_wdat", wbwdat, e.wdat);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic dre, input logic dwe, input logic halt, input logic m2r,
                       input logic wen, input logic lui, input logic [4:0] ws,
                       input logic [31:0] port, input logic [31:0] rd2,
                       input logic [31:0] ins, input logic en);
    memcuDRE = dre; memcuDWE = dwe; memcuHALT = halt; memMemToReg = m2r;
    memWEN = wen; memLUIflag = lui; memwsel = ws; memOutput_Port = port;
    memrdat2 = rd2; meminstr = ins; memEN = en;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1);
  endtask

  initial begin
    nRST = 1'b0;
    dhit = 1'b0;
    dmemload = 32'h0;
    drive(1, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 1);  // access pending during reset
    #3;
    chk("rst_dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("rst_dmemWEN", {31'd0, dmemWEN}, 32'd0);
    chk("rst_dmemaddr", dmemaddr, 32'd0);
    chk("rst_memStall", {31'd0, memStall}, 32'd0);
    chk("rst_memErr", {31'd0, memErr}, 32'd0);
    chk("rst_wbWEN", {31'd0, wbWEN}, 32'd0);
    chk("rst_wbwdat", wbwdat, 32'd0);
    chk("rst_wbHALT", {31'd0, wbHALT}, 32'd0);
    nop();
    step();
    nRST = 1'b1;
    step();

    // ALU result passes straight through.
    drive(0, 0, 0, 0, 1, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 1);
    push(5'd5, 32'h1234);
    #1;
    chk("alu_dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("alu_dmemWEN", {31'd0, dmemWEN}, 32'd0);
    chk("alu_memStall", {31'd0, memStall}, 32'd0);
    step();
    nop();
    step();

    // Load with 3 wait cycles: stall and bubbles, then load data.
    drive(1, 0, 0, 1, 1, 0, 5'd7, 32'h100, 32'h0, 32'h0, 1);
    push(5'd7, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_dmemREN", {31'd0, dmemREN}, 32'd1);
      chk("ld_dmemaddr", dmemaddr, 32'h100);
      chk("ld_memStall", {31'd0, memStall}, 32'd1);
      step();
      chk("ld_bubble_wbWEN", {31'd0, wbWEN}, 32'd0);
    end
    dhit = 1'b1;
    dmemload = 32'hDEADBEEF;
    #1;
    chk("ld_hit_memStall", {31'd0, memStall}, 32'd0);
    step();
    dhit = 1'b0;
    nop();
    step();

    // Store with zero-wait dhit while memEN is low: one pulse, park, no re-issue.
    drive(1, 1, 0, 0, 0, 0, 5'd0, 32'h200, 32'hCAFE, 32'h0, 0);
    dhit = 1'b1;
    #1;
    chk("st_dmemWEN", {31'd0, dmemWEN}, 32'd1);
    chk("st_dmemREN_prio", {31'd0, dmemREN}, 32'd0);
    chk("st_dmemstore", dmemstore, 32'hCAFE);
    chk("st_memStall", {31'd0, memStall}, 32'd0);
    step();
    dhit = 1'b0;
    chk("st_done_dmemWEN", {31'd0, dmemWEN}, 32'd0);
    chk("st_done_memStall", {31'd0, memStall}, 32'd0);
    step();
    chk("st_done2_dmemWEN", {31'd0, dmemWEN}, 32'd0);
    memEN = 1'b1;
    step();
    // Back in IDLE: the still-presented store is visible again.
    chk("st_retired_idle", {31'd0, dmemWEN}, 32'd1);
    nop();
    step();

    // Load hit while frozen: captured data survives dmemload changing.
    drive(1, 0, 0, 1, 1, 0, 5'd11, 32'h104, 32'h0, 32'h0, 0);
    dhit = 1'b1;
    dmemload = 32'h55AA55AA;
    push(5'd11, 32'h55AA55AA);
    step();
    dhit = 1'b0;
    dmemload = 32'h0BAD0BAD;
    chk("ldd_no_reissue", {31'd0, dmemREN}, 32'd0);
    chk("ldd_hold_wbWEN", {31'd0, wbWEN}, 32'd0);
    memEN = 1'b1;
    step();
    nop();
    step();

    // LUI.
    drive(0, 0, 0, 0, 1, 1, 5'd9, 32'hFFFF, 32'h0, 32'h1234ABCD, 1);
    push(5'd9, 32'hABCD0000);
    step();
    nop();
    step();

    // Aligned load never hit: timeout sets memErr, FSM keeps requesting.
    drive(1, 0, 0, 1, 1, 0, 5'd2, 32'h300, 32'h0, 32'h0, 1);
    for (int i = 0; i < 250; i++) step();
    chk("tmo_before_memErr", {31'd0, memErr}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("tmo_memErr", {31'd0, memErr}, 32'd1);
    chk("tmo_still_req", {31'd0, dmemREN}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("tmo_rst_dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("tmo_rst_memErr", {31'd0, memErr}, 32'd0);
    nop();
    step();
    nRST = 1'b1;
    step();

    // Misaligned load: memErr sticky, access still issued; reset mid-BUSY.
    drive(1, 0, 0, 1, 1, 0, 5'd2, 32'h102, 32'h0, 32'h0, 1);
    #1;
    chk("mis_memStall", {31'd0, memStall}, 32'd1);
    step();
    chk("mis_memErr", {31'd0, memErr}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("mis_memErr_sticky", {31'd0, memErr}, 32'd1);
    chk("mis_dmemREN", {31'd0, dmemREN}, 32'd1);
    chk("mis_dmemaddr", dmemaddr, 32'h102);
    nRST = 1'b0;
    #1;
    chk("mis_rst_dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("mis_rst_memStall", {31'd0, memStall}, 32'd0);
    chk("mis_rst_memErr", {31'd0, memErr}, 32'd0);
    nop();
    step();
    nRST = 1'b1;
    step();

    // Halt retires, then no further requests or writes.
    drive(0, 0, 1, 0, 1, 0, 5'd3, 32'h77, 32'h0, 32'h0, 1);
    push(5'd3, 32'h77);
    step();
    chk("halt_wbHALT", {31'd0, wbHALT}, 32'd1);
    drive(1, 0, 0, 0, 1, 0, 5'd4, 32'h400, 32'h0, 32'h0, 1);
    #1;
    chk("halt_no_dmemREN", {31'd0, dmemREN}, 32'd0);
    chk("halt_memStall", {31'd0, memStall}, 32'd0);
    step();
    chk("halt_wbWEN", {31'd0, wbWEN}, 32'd0);
    chk("halt_wbHALT_sticky", {31'd0, wbHALT}, 32'd1);
    step();
    step();

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage pipeline.
- Consumes the EX/MEM latch outputs: memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN, memLUIflag, memwsel, memOutput_Port, memrdat2, meminstr.
- Drives the data-side memory handshake (dREN/dWEN until dhit) and asserts a stall to the hazard unit while an access is outstanding.
- Owns the MEM/WB latch and delivers the final writeback word, select and enable to the register file.

Parameters:
- TIMEOUT, 255, dhit wait cycles before memErr asserts (counter width $clog2(TIMEOUT+1)).

Ports:
- CLK  input  1  system clock; all state on rising edge
- nRST  input  1  asynchronous active-low reset
- memEN  input  1  hazard-unit advance enable for the MEM/WB latch
- memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN, memLUIflag  input  1 each  EX/MEM control
- memwsel  input  5  destination register
- memOutput_Port  input  32  ALU result / data address
- memrdat2  input  32  store data
- meminstr  input  32  instruction (LUI immediate source)
- dhit  input  1  memory access complete
- dmemload  input  32  load data, valid with dhit
- dmemREN  output  1  read request
- dmemWEN  output  1  write request
- dmemaddr  output  32  access address
- dmemstore  output  32  store data
- memStall  output  1  stage cannot retire this cycle
- memErr  output  1  sticky: misaligned address or timeout
- wbWEN  output  1  register-file write enable
- wbwsel  output  5  register-file write select
- wbwdat  output  32  register-file write data
- wbHALT  output  1  sticky halt to top level

Behaviour:
- Reset (async, nRST=0): state IDLE; all outputs 0; captured load and timeout counter cleared.
- FSM states: IDLE, BUSY, DONE, HALTED.
- IDLE, no access (DRE=DWE=0): memStall=0; MEM/WB latch loads on memEN.
- IDLE, access (DRE|DWE): go BUSY this edge.
  - Requests are combinational from the EX/MEM inputs in IDLE and BUSY: dmemREN=DRE, dmemWEN=DWE, dmemaddr=memOutput_Port, dmemstore=memrdat2.
  - memStall=~dhit.
  - Both DRE and DWE set: write takes priority, dmemREN forced 0.
- BUSY: request held stable until dhit. Timeout counter increments each non-dhit cycle.
  - On dhit: capture dmemload.
    - memEN=1: retire to MEM/WB, go IDLE.
    - memEN=0: go DONE.
- DONE: no request, memStall=0, captured data held; retire on memEN, then IDLE. This prevents re-issuing an access when upstream freezes.
- dhit in the same cycle the request first appears (IDLE): zero-wait; retire directly if memEN, else go DONE.
- Misaligned address (addr[1:0]!=0) with an access: memErr set sticky. Access still issued.
- Timeout counter reaching TIMEOUT: memErr set sticky, FSM remains BUSY.
- Writeback data:
  - memLUIflag: {meminstr[15:0],16'h0}
  - else memMemToReg: load data
  - else memOutput_Port
- MEM/WB latch:
  - memEN=1 and memStall=0: latch loads wbWEN=memWEN, wbwsel, wbwdat.
  - memStall=1: latch loads bubble (wbWEN=0).
  - memEN=0 otherwise: latch holds.
- memcuHALT retiring: wbHALT=1, go HALTED. In HALTED, no further requests, wbWEN=0, memStall=0; only reset exits.
- Reset mid-BUSY: requests drop immediately (async), state IDLE.

Optional Feature:
- MEM_STAGE_PERF_EN defined: adds output perfAccesses (32), counting accesses retired, and output perfStallCycles (32), counting cycles with memStall=1. Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- cpu_types_pkg gains memstate_t (IDLE, BUSY, DONE, HALTED) and WORD_ALIGN_MASK=2'b11.
- word_t is reused.
- One natural sub-module: mem_wb_latch (MEM/WB register with enable/bubble); FSM and muxing stay in mem_stage.

Test Plan:
- ALU op, memWEN=1, memwsel=5, memOutput_Port=32'h1234, memEN=1 -> next edge wbWEN=1, wbwsel=5, wbwdat=32'h1234; dmemREN=dmemWEN=0.
- Load addr 32'h100, dhit after 3 cycles, dmemload=32'hDEADBEEF, MemToReg=1 -> dmemREN=1, memStall=1 for 3 cycles, wbWEN=0 bubbles, then wbwdat=32'hDEADBEEF.
- Store addr 32'h200, rdat2=32'hCAFE, dhit in cycle 1, memEN=0 for 2 cycles -> single dmemWEN pulse with store 32'hCAFE, FSM DONE, no re-issue, retire when memEN=1.
- LUI meminstr[15:0]=16'hABCD -> wbwdat=32'hABCD0000.
- Load addr 32'h102, dhit withheld TIMEOUT cycles -> memErr=1 on misalignment immediately, stays 1; nRST low mid-BUSY -> dmemREN=0 instantly, memErr=0.
- memcuHALT with memEN=1 -> wbHALT=1 next edge; subsequent DRE=1 produces no dmemREN.
